// File: rtl/dioptase_pkg.sv
// Shared interrupt-controller constants: register word offsets and default base address.
// Also consumed by top-level integration and software headers.
package dioptase_pkg;

    localparam logic [17:0] IRQ_BASE_ADDR = 18'h3FF00;

    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_MASK    = 3'd1;
    localparam logic [2:0] IRQ_EDGE    = 3'd2;
    localparam logic [2:0] IRQ_FORCE   = 3'd3;
    localparam logic [2:0] IRQ_ACTIVE  = 3'd4;

    // Expand the 4 byte write enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] wen);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wen[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_controller_sync.sv
// Multi-stage synchroniser for asynchronous request lines, with a one-cycle
// history copy of the final stage for rising-edge detection.
module irq_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_prev
);

    logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else if (gi == 0) begin
                    stage_reg[gi] <= async_in;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign s = stage_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev <= '0;
        end else begin
            s_prev <= s;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronises request lines into PENDING,
// snoops CPU writes for PENDING/MASK/EDGE/FORCE and serves registered reads.
module irq_controller
    import dioptase_pkg::*;
#(
    parameter int          NUM_SRC     = 16,
    parameter logic [17:0] BASE_ADDR   = IRQ_BASE_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [3:0]         wen,
    input  logic [17:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic [17:0]        raddr,
    output logic [31:0]        rdata,
    output logic               rhit,
    output logic [NUM_SRC-1:0] interrupts
);

    logic [NUM_SRC-1:0] s, s_prev;
    logic [NUM_SRC-1:0] pending_reg, mask_reg, edge_reg;
    logic [NUM_SRC-1:0] pending_next, set_bits, clr_bits, wsrc, bm_src;
    logic [31:0]        wbits, rd_word;
    logic [17:0]        w_off, r_off;
    logic               w_hit, r_in_range;
    logic               wr_pending, wr_mask, wr_edge, wr_force;

    irq_sync #(
        .WIDTH       (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq_src),
        .s        (s),
        .s_prev   (s_prev)
    );

    // Subtraction wraps addresses below the base to large values, so one compare covers both bounds.
    assign w_off      = waddr - BASE_ADDR;
    assign r_off      = raddr - BASE_ADDR;
    assign w_hit      = clk_en && (wen != 4'b0000) && (w_off < 18'd8);
    assign r_in_range = r_off < 18'd8;

    assign wbits  = wdata & byte_mask(wen);
    assign wsrc   = wbits[NUM_SRC-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_bm
            assign bm_src[gi] = wen[gi / 8];
        end
    endgenerate

    assign wr_pending = w_hit && (w_off[2:0] == IRQ_PENDING);
    assign wr_mask    = w_hit && (w_off[2:0] == IRQ_MASK);
    assign wr_edge    = w_hit && (w_off[2:0] == IRQ_EDGE);
    assign wr_force   = w_hit && (w_off[2:0] == IRQ_FORCE);

    // Set is ORed after the clear so a same-cycle request always survives a W1C.
    assign set_bits     = (edge_reg & s & ~s_prev) | (~edge_reg & s) | (wr_force ? wsrc : '0);
    assign clr_bits     = wr_pending ? wsrc : '0;
    assign pending_next = (pending_reg & ~clr_bits) | set_bits;

    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            case (r_off[2:0])
                IRQ_PENDING: rd_word[NUM_SRC-1:0] = pending_reg;
                IRQ_MASK:    rd_word[NUM_SRC-1:0] = mask_reg;
                IRQ_EDGE:    rd_word[NUM_SRC-1:0] = edge_reg;
                IRQ_ACTIVE:  rd_word[NUM_SRC-1:0] = pending_reg & mask_reg;
                default:     rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            edge_reg    <= '0;
            interrupts  <= '0;
            rdata       <= '0;
            rhit        <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (wr_mask) begin
                mask_reg <= (mask_reg & ~bm_src) | wsrc;
            end
            if (wr_edge) begin
                edge_reg <= (edge_reg & ~bm_src) | wsrc;
            end
            interrupts <= pending_reg & mask_reg;
            if (clk_en) begin
                rdata <= rd_word;
                rhit  <= r_in_range;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: read results are queued as expected
// {rhit, rdata} when a read is issued and popped when the DUT returns data.
module tb_irq_controller;

    localparam logic [17:0] BASE = 18'h3FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [15:0] irq_src;
    logic [3:0]  wen;
    logic [17:0] waddr;
    logic [31:0] wdata;
    logic [17:0] raddr;
    logic [31:0] rdata;
    logic        rhit;
    logic [15:0] interrupts;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [32:0] exp_q [$];
    logic [32:0] exp_v;

    irq_controller #(
        .NUM_SRC     (16),
        .BASE_ADDR   (18'h3FF00),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .irq_src    (irq_src),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rhit       (rhit),
        .interrupts (interrupts)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        waddr = BASE + 18'(off);
        wdata = d;
        wen   = be;
        tick();
        wen   = 4'b0000;
        $display("WRITE off=%0d data=%h wen=%b clk_en=%0b", off, d, be, clk_en);
    endtask

    // Present raddr for one edge and queue what the DUT should return.
    task automatic rd(input int off, input logic [32:0] exp);
        raddr = BASE + 18'(off);
        exp_q.push_back(exp);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({interrupts, rhit, rdata} !== 49'h0)
            $display("FAIL reset_outputs got irq=%h rhit=%0b rdata=%h exp all 0", interrupts, rhit, rdata);
        else pass_cnt++;
        rst = 1'b0;
        for (int off = 0; off < 3; off++) begin
            rd(off, {1'b1, 32'h0});
            exp_v = exp_q.pop_front();
            total_cnt++;
            if ({rhit, rdata} !== exp_v) $display("FAIL reset_read%0d got %h exp %h", off, {rhit, rdata}, exp_v);
            else pass_cnt++;
            $display("READ off=%0d got %h exp %h", off, {rhit, rdata}, exp_v);
        end
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL idle_irq got %h exp 0000", interrupts);
        else pass_cnt++;
    endtask

    task automatic test_edge();
        wr(1, 32'h1, 4'hF);
        wr(2, 32'h1, 4'hF);
        irq_src[0] = 1'b1;
        tick();  // E0
        tick();  // E1
        tick();  // E2
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL edge_early got %h exp 0000", interrupts);
        else pass_cnt++;
        tick();  // E3
        total_cnt++;
        if (interrupts !== 16'h0001) $display("FAIL edge_latency got %h exp 0001", interrupts);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) tick();
        irq_src[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (interrupts !== 16'h0001) $display("FAIL edge_sticky got %h exp 0001", interrupts);
        else pass_cnt++;
        wr(0, 32'h1, 4'b0001);
        tick();
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL edge_w1c got %h exp 0000", interrupts);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL edge_no_repend got %h exp 0000", interrupts);
        else pass_cnt++;
    endtask

    task automatic test_level();
        wr(2, 32'h0, 4'hF);
        wr(1, 32'h4, 4'hF);
        irq_src[2] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (interrupts !== 16'h0004) $display("FAIL level_set got %h exp 0004", interrupts);
        else pass_cnt++;
        wr(0, 32'h4, 4'hF);
        tick();
        total_cnt++;
        if (interrupts !== 16'h0004) $display("FAIL level_reassert got %h exp 0004", interrupts);
        else pass_cnt++;
        irq_src[2] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wr(0, 32'h4, 4'hF);
        tick();
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL level_clear got %h exp 0000", interrupts);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL level_stays_clear got %h exp 0000", interrupts);
        else pass_cnt++;
    endtask

    task automatic test_mask_force();
        logic [32:0] exp_tbl [4];
        int          off_tbl [4];
        exp_tbl = '{{1'b1, 32'h8001}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}};
        off_tbl = '{0, 4, 3, 1};
        wr(1, 32'h0, 4'hF);
        wr(3, 32'h8001, 4'hF);
        for (int i = 0; i < 4; i++) begin
            rd(off_tbl[i], exp_tbl[i]);
            exp_v = exp_q.pop_front();
            total_cnt++;
            if ({rhit, rdata} !== exp_v) $display("FAIL force_read off=%0d got %h exp %h", off_tbl[i], {rhit, rdata}, exp_v);
            else pass_cnt++;
            $display("READ off=%0d got %h exp %h", off_tbl[i], {rhit, rdata}, exp_v);
        end
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL force_masked got %h exp 0000", interrupts);
        else pass_cnt++;
        wr(1, 32'h8000, 4'hF);
        total_cnt++;
        if (interrupts !== 16'h0) $display("FAIL mask_too_early got %h exp 0000", interrupts);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (interrupts !== 16'h8000) $display("FAIL mask_unmask got %h exp 8000", interrupts);
        else pass_cnt++;
        rd(4, {1'b1, 32'h8000});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL active_read got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        wr(0, 32'hFFFF, 4'hF);
    endtask

    task automatic test_simul_bytes();
        wr(1, 32'hFFFF_FFFF, 4'b0010);
        rd(1, {1'b1, 32'hFF00});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL byte_mask_write got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        wr(2, 32'h2, 4'hF);
        irq_src[1] = 1'b1;
        tick();  // E0
        tick();  // E1
        wr(0, 32'h2, 4'hF);  // W1C lands on the same edge the edge-set does
        rd(0, {1'b1, 32'h0002});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL set_beats_w1c got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        rd(8, {1'b0, 32'h0});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL oob_high got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        rd(-1, {1'b0, 32'h0});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL oob_low got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        rd(6, {1'b1, 32'h0});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL reserved_read got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        wr(8, 32'hFFFF, 4'hF);  // out of range, must not alter MASK
        rd(1, {1'b1, 32'hFF00});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL oob_write got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_clk_en_reset();
        clk_en = 1'b0;
        wr(1, 32'h1234, 4'hF);
        rd(0, {1'b1, 32'hFF00});  // rdata must hold the previous MASK read
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL rdata_hold got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        clk_en = 1'b1;
        rd(1, {1'b1, 32'hFF00});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL clk_en_write got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        wr(3, 32'hFFFF, 4'hF);
        wr(1, 32'hFFFF, 4'hF);
        tick();
        total_cnt++;
        if (interrupts !== 16'hFFFF) $display("FAIL pre_reset got %h exp ffff", interrupts);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({interrupts, rhit, rdata} !== 49'h0)
            $display("FAIL mid_reset got irq=%h rhit=%0b rdata=%h exp all 0", interrupts, rhit, rdata);
        else pass_cnt++;
        rst = 1'b0;
        tick();  // E0: irq_src[1] still high, now a level source
        tick();  // E1
        rd(0, {1'b1, 32'h0});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL post_reset_early got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        rd(0, {1'b1, 32'h0002});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL post_reset_repend got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
        rd(1, {1'b1, 32'h0});
        exp_v = exp_q.pop_front();
        total_cnt++;
        if ({rhit, rdata} !== exp_v) $display("FAIL post_reset_mask got %h exp %h", {rhit, rdata}, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        rst     = 1'b1;
        clk_en  = 1'b1;
        irq_src = '0;
        wen     = '0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        test_reset();
        test_edge();
        test_level();
        test_mask_force();
        test_simul_bytes();
        test_clk_en_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
